// File: rtl/rvga_types.sv
// Shared types for the rvga test-memory front end: arbiter state,
// requester identity and the sub-word store merge helper.
package rvga_types;

  typedef logic [31:0] rvga_word;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_IF_RD  = 3'd1,
    ARB_D_RD   = 3'd2,
    ARB_RMW_RD = 3'd3,
    ARB_WR     = 3'd4,
    ARB_DONE   = 3'd5
  } arb_state_e;

  typedef enum logic {
    ARB_IF   = 1'b0,
    ARB_DATA = 1'b1
  } arb_port_e;

  // Byte k of the result comes from the store data when be[k] is set.
  function automatic rvga_word be_merge(input rvga_word wdata,
                                        input rvga_word rdata,
                                        input logic [3:0] be);
    rvga_word merged;
    merged = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = be[k] ? wdata[8*k +: 8] : rdata[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rvga_mem_arbiter_chk.sv
// Simulation-only observer for the arbiter: flags the illegal
// load+store request and optionally traces grants and memory responses.
module rvga_mem_arbiter_chk #(
  parameter int unsigned debug_p = 0
) (
  input logic        clk_i,
  input logic        rst_n_i,
  input logic        d_r_v_i,
  input logic        d_w_v_i,
  input logic        if_grant_i,
  input logic        d_grant_i,
  input logic        mem_strobe_i,
  input logic        mem_resp_v_i,
  input logic [31:0] mem_addr_i,
  input logic [31:0] mem_rdata_i
);

  // Illegal request check and debug trace.
  always @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(d_r_v_i && d_w_v_i))
        else $error("rvga_mem_arbiter: load and store requested together");
      if (debug_p != 0) begin
        if (if_grant_i) $display("%t arb grant IF", $time);
        if (d_grant_i) $display("%t arb grant DATA", $time);
        if (mem_strobe_i && mem_resp_v_i)
          $display("%t arb mem resp addr=%h rdata=%h", $time, mem_addr_i, mem_rdata_i);
      end
    end
  end

endmodule

// File: rtl/rvga_timeout_ctr.sv
// Wait-cycle counter for one memory phase; expired_o flags the cycle in
// which the limit_p-th consecutive wait cycle is spent without a response.
module rvga_timeout_ctr #(
  parameter int unsigned limit_p = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned width_lp = $clog2(limit_p + 1);

  logic [width_lp-1:0] count_q, count_d;

  assign expired_o = en_i && (count_q == width_lp'(limit_p - 1));

  // Next count: clear has priority, saturate once expired.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + width_lp'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Round-robin fetch/data front end to the word-wide test memory; one
// transaction at a time, sub-word stores done as read-modify-write.
module rvga_mem_arbiter
  import rvga_types::*;
#(
  parameter int unsigned debug_p   = 0,
  parameter int unsigned timeout_p = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_v_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_data_o,
  output logic        if_resp_v_o,
  output logic        if_err_o,
  input  logic        d_r_v_i,
  input  logic        d_w_v_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_ready_o,
  output logic [31:0] d_rdata_o,
  output logic        d_resp_v_o,
  output logic        d_err_o,
  output logic        mem_r_v_o,
  output logic        mem_w_v_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_resp_v_i
);

  arb_state_e state_q, state_d;
  arb_port_e  last_grant_q, last_grant_d;
  arb_port_e  owner_q, owner_d;
  logic       err_q, err_d;
  logic [3:0] be_q, be_d;
  rvga_word   mem_addr_q, mem_addr_d;
  rvga_word   mem_wdata_q, mem_wdata_d;
  rvga_word   if_data_q, if_data_d;
  rvga_word   d_rdata_q, d_rdata_d;

  logic d_v_s, idle_s, in_mem_s, if_win_s, d_win_s, done_s, expired_s;

  assign d_v_s    = d_r_v_i | d_w_v_i;
  assign idle_s   = (state_q == ARB_IDLE);
  assign done_s   = (state_q == ARB_DONE);
  assign in_mem_s = (state_q == ARB_IF_RD) || (state_q == ARB_D_RD) ||
                    (state_q == ARB_RMW_RD) || (state_q == ARB_WR);
  // On a tie the port that did not win last time is granted.
  assign if_win_s = idle_s && if_v_i && (!d_v_s || (last_grant_q == ARB_DATA));
  assign d_win_s  = idle_s && d_v_s && (!if_v_i || (last_grant_q == ARB_IF));

  generate
    if (timeout_p > 0) begin : g_tmo
      rvga_timeout_ctr #(.limit_p(timeout_p)) u_tmo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (!in_mem_s || mem_resp_v_i),
        .en_i      (in_mem_s && !mem_resp_v_i),
        .expired_o (expired_s)
      );
    end else begin : g_no_tmo
      assign expired_s = 1'b0;
    end
  endgenerate

  // Next-state and captured-request logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    err_d        = err_q;
    be_d         = be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_data_d    = if_data_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (if_win_s) begin
          state_d      = ARB_IF_RD;
          owner_d      = ARB_IF;
          last_grant_d = ARB_IF;
          err_d        = 1'b0;
          mem_addr_d   = if_addr_i & 32'hFFFF_FFFC;
        end else if (d_win_s) begin
          owner_d      = ARB_DATA;
          last_grant_d = ARB_DATA;
          err_d        = 1'b0;
          mem_addr_d   = d_addr_i & 32'hFFFF_FFFC;
          mem_wdata_d  = d_wdata_i;
          be_d         = d_be_i;
          // A simultaneous load+store is handled as the store.
          if (d_w_v_i) begin
            if (d_be_i == 4'hF) begin
              state_d = ARB_WR;
            end else if (d_be_i == 4'h0) begin
              state_d = ARB_DONE;
            end else begin
              state_d = ARB_RMW_RD;
            end
          end else begin
            state_d = ARB_D_RD;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_IF_RD: begin
        if (mem_resp_v_i) begin
          if_data_d = mem_rdata_i;
          state_d   = ARB_DONE;
        end else if (expired_s) begin
          err_d   = 1'b1;
          state_d = ARB_DONE;
        end else begin
          state_d = ARB_IF_RD;
        end
      end
      ARB_D_RD: begin
        if (mem_resp_v_i) begin
          d_rdata_d = mem_rdata_i;
          state_d   = ARB_DONE;
        end else if (expired_s) begin
          err_d   = 1'b1;
          state_d = ARB_DONE;
        end else begin
          state_d = ARB_D_RD;
        end
      end
      ARB_RMW_RD: begin
        if (mem_resp_v_i) begin
          mem_wdata_d = be_merge(mem_wdata_q, mem_rdata_i, be_q);
          state_d     = ARB_WR;
        end else if (expired_s) begin
          err_d   = 1'b1;
          state_d = ARB_DONE;
        end else begin
          state_d = ARB_RMW_RD;
        end
      end
      ARB_WR: begin
        if (mem_resp_v_i) begin
          state_d = ARB_DONE;
        end else if (expired_s) begin
          err_d   = 1'b1;
          state_d = ARB_DONE;
        end else begin
          state_d = ARB_WR;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ARB_DATA;
      owner_q      <= ARB_IF;
      err_q        <= 1'b0;
      be_q         <= 4'h0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      if_data_q    <= 32'h0000_0000;
      d_rdata_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      be_q         <= be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_data_q    <= if_data_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_ready_o  = if_win_s;
  assign d_ready_o   = d_win_s;
  assign if_data_o   = if_data_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_resp_v_o = done_s && (owner_q == ARB_IF);
  assign d_resp_v_o  = done_s && (owner_q == ARB_DATA);
  assign if_err_o    = if_resp_v_o && err_q;
  assign d_err_o     = d_resp_v_o && err_q;
  assign mem_r_v_o   = (state_q == ARB_IF_RD) || (state_q == ARB_D_RD) ||
                       (state_q == ARB_RMW_RD);
  assign mem_w_v_o   = (state_q == ARB_WR);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  rvga_mem_arbiter_chk #(.debug_p(debug_p)) u_chk (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .d_r_v_i      (d_r_v_i),
    .d_w_v_i      (d_w_v_i),
    .if_grant_i   (if_win_s),
    .d_grant_i    (d_win_s),
    .mem_strobe_i (in_mem_s),
    .mem_resp_v_i (mem_resp_v_i),
    .mem_addr_i   (mem_addr_q),
    .mem_rdata_i  (mem_rdata_i)
  );

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed bench for rvga_mem_arbiter against an identity-initialised
// zero-wait memory that can be switched to never respond.
module tb_rvga_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_v;
  logic [31:0] if_addr;
  logic        if_ready, if_resp_v, if_err;
  logic [31:0] if_data;
  logic        d_r_v, d_w_v;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_ready, d_resp_v, d_err;
  logic [31:0] d_rdata;
  logic        mem_r_v, mem_w_v, mem_resp_v;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_en;
  logic [31:0] mem [64];

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  rvga_mem_arbiter #(.debug_p(0), .timeout_p(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_v_i(if_v), .if_addr_i(if_addr), .if_ready_o(if_ready),
    .if_data_o(if_data), .if_resp_v_o(if_resp_v), .if_err_o(if_err),
    .d_r_v_i(d_r_v), .d_w_v_i(d_w_v), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_be_i(d_be), .d_ready_o(d_ready), .d_rdata_o(d_rdata),
    .d_resp_v_o(d_resp_v), .d_err_o(d_err),
    .mem_r_v_o(mem_r_v), .mem_w_v_o(mem_w_v), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_resp_v_i(mem_resp_v)
  );

  assign mem_resp_v = mem_en && (mem_r_v || mem_w_v);
  assign mem_rdata  = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_w_v && mem_resp_v) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Zero-wait load: accept, strobe, response.
  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    d_r_v = 1'b1; d_addr = a;
    #1 chk({tag, "_rdy"}, 32'(d_ready), 32'd1);
    @(negedge clk); d_r_v = 1'b0;
    chk({tag, "_strobe"}, 32'(mem_r_v), 32'd1);
    chk({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
    @(negedge clk);
    chk({tag, "_resp"}, 32'(d_resp_v), 32'd1);
    chk({tag, "_err"}, 32'(d_err), 32'd0);
    chk({tag, "_data"}, d_rdata, exp);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i * 4);
    rst_n = 1'b0; mem_en = 1'b1;
    if_v = 1'b0; if_addr = 32'h0; d_r_v = 1'b0; d_w_v = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_mem_r", 32'(mem_r_v), 32'd0);
    chk("rst_mem_w", 32'(mem_w_v), 32'd0);
    chk("rst_if_resp", 32'(if_resp_v), 32'd0);
    chk("rst_d_resp", 32'(d_resp_v), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_data", if_data, 32'h0);

    // Single fetch at 0x10.
    rst_n = 1'b1; if_v = 1'b1; if_addr = 32'h10;
    #1 chk("f_rdy", 32'(if_ready), 32'd1);
    @(negedge clk); if_v = 1'b0;
    chk("f_strobe", 32'(mem_r_v), 32'd1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_resp_early", 32'(if_resp_v), 32'd0);
    @(negedge clk);
    chk("f_strobe_off", 32'(mem_r_v), 32'd0);
    chk("f_resp", 32'(if_resp_v), 32'd1);
    chk("f_data", if_data, 32'h10);
    chk("f_err", 32'(if_err), 32'd0);
    @(negedge clk);
    chk("f_resp_once", 32'(if_resp_v), 32'd0);

    // Both ports held valid from reset: grants alternate starting with IF.
    rst_n = 1'b0; if_v = 1'b1; if_addr = 32'h0; d_r_v = 1'b1; d_addr = 32'h4;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_if_rdy", 32'(if_ready), 32'((k % 2) == 0));
      chk("rr_d_rdy", 32'(d_ready), 32'((k % 2) == 1));
      @(negedge clk);
      chk("rr_addr", mem_addr, ((k % 2) == 0) ? 32'h0 : 32'h4);
      @(negedge clk);
      chk("rr_if_resp", 32'(if_resp_v), 32'((k % 2) == 0));
      chk("rr_d_resp", 32'(d_resp_v), 32'((k % 2) == 1));
      if ((k % 2) == 1) chk("rr_d_data", d_rdata, 32'h4);
      else chk("rr_if_data", if_data, 32'h0);
      @(negedge clk);
    end
    if_v = 1'b0; d_r_v = 1'b0;

    // Sub-word store be=0100 at 0x8: read, merged write, later readback.
    d_w_v = 1'b1; d_addr = 32'h8; d_wdata = 32'hAABB_CCDD; d_be = 4'b0100;
    #1 chk("rmw_rdy", 32'(d_ready), 32'd1);
    @(negedge clk); d_w_v = 1'b0;
    chk("rmw_rd", 32'(mem_r_v), 32'd1);
    chk("rmw_rd_w", 32'(mem_w_v), 32'd0);
    @(negedge clk);
    chk("rmw_wr", 32'(mem_w_v), 32'd1);
    chk("rmw_wr_r", 32'(mem_r_v), 32'd0);
    chk("rmw_wdata", mem_wdata, 32'h00BB_0008);
    @(negedge clk);
    chk("rmw_resp", 32'(d_resp_v), 32'd1);
    chk("rmw_rdata_kept", d_rdata, 32'h4);
    @(negedge clk);
    load(32'h8, 32'h00BB_0008, "ld8");

    // be=0101 at 0x18 over 0x00000018.
    d_w_v = 1'b1; d_addr = 32'h18; d_be = 4'b0101;
    #1 chk("rmw2_rdy", 32'(d_ready), 32'd1);
    @(negedge clk); d_w_v = 1'b0;
    @(negedge clk);
    chk("rmw2_wdata", mem_wdata, 32'h00BB_00DD);
    @(negedge clk);
    chk("rmw2_resp", 32'(d_resp_v), 32'd1);
    @(negedge clk);
    load(32'h18, 32'h00BB_00DD, "ld18");

    // be=0 store: no memory access, response one cycle after accept.
    d_w_v = 1'b1; d_addr = 32'h1C; d_wdata = 32'hFFFF_FFFF; d_be = 4'h0;
    #1 chk("be0_rdy", 32'(d_ready), 32'd1);
    @(negedge clk); d_w_v = 1'b0;
    chk("be0_resp", 32'(d_resp_v), 32'd1);
    chk("be0_no_r", 32'(mem_r_v), 32'd0);
    chk("be0_no_w", 32'(mem_w_v), 32'd0);
    chk("be0_rdata_kept", d_rdata, 32'h00BB_00DD);
    @(negedge clk);

    // Full-word store to unaligned 0xE lands at 0xC.
    d_w_v = 1'b1; d_addr = 32'hE; d_wdata = 32'h1234_5678; d_be = 4'hF;
    #1 chk("wf_rdy", 32'(d_ready), 32'd1);
    @(negedge clk); d_w_v = 1'b0;
    chk("wf_w", 32'(mem_w_v), 32'd1);
    chk("wf_r", 32'(mem_r_v), 32'd0);
    chk("wf_addr", mem_addr, 32'hC);
    chk("wf_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("wf_resp", 32'(d_resp_v), 32'd1);
    @(negedge clk);
    load(32'hC, 32'h1234_5678, "ldC");

    // Unresponsive memory: 4 strobe cycles, then error response.
    mem_en = 1'b0; d_r_v = 1'b1; d_addr = 32'h20;
    #1 chk("to_rdy", 32'(d_ready), 32'd1);
    @(negedge clk); d_r_v = 1'b0;
    chk("to_strobe", 32'(mem_r_v), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("to_strobe", 32'(mem_r_v), 32'd1);
      chk("to_no_resp", 32'(d_resp_v), 32'd0);
    end
    @(negedge clk);
    chk("to_strobe_off", 32'(mem_r_v), 32'd0);
    chk("to_resp", 32'(d_resp_v), 32'd1);
    chk("to_err", 32'(d_err), 32'd1);
    chk("to_rdata_kept", d_rdata, 32'h1234_5678);
    mem_en = 1'b1;
    @(negedge clk);
    chk("to_err_clr", 32'(d_err), 32'd0);
    load(32'h20, 32'h20, "ld20");

    // Reset while in the RMW write phase.
    d_w_v = 1'b1; d_addr = 32'h30; d_wdata = 32'h0000_00EE; d_be = 4'b0001;
    #1 chk("rr_rmw_rdy", 32'(d_ready), 32'd1);
    @(negedge clk); d_w_v = 1'b0;
    chk("rr_rmw_rd", 32'(mem_r_v), 32'd1);
    @(negedge clk);
    chk("rr_rmw_wr", 32'(mem_w_v), 32'd1);
    rst_n = 1'b0; if_v = 1'b1; if_addr = 32'h10; d_r_v = 1'b1; d_addr = 32'h4;
    @(negedge clk);
    chk("rr_w_off", 32'(mem_w_v), 32'd0);
    chk("rr_r_off", 32'(mem_r_v), 32'd0);
    chk("rr_no_dresp", 32'(d_resp_v), 32'd0);
    chk("rr_no_ifresp", 32'(if_resp_v), 32'd0);
    chk("rr_wdata0", mem_wdata, 32'h0);
    chk("rr_rdata0", d_rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rr_tie_if", 32'(if_ready), 32'd1);
    chk("rr_tie_d", 32'(d_ready), 32'd0);
    @(negedge clk); if_v = 1'b0; d_r_v = 1'b0;
    chk("rr_f_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk("rr_f_resp", 32'(if_resp_v), 32'd1);
    chk("rr_f_data", if_data, 32'h10);
    chk("rr_f_dresp", 32'(d_resp_v), 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
